// File: rtl/controle_exibicao_if.sv
// ============================================================================
// Module      : controle_exibicao_if
// Description : Bus bundle between the sequence-playback controller and its host.
//               Macro CONTROLE_EXIBICAO_DB_ESTADO_EN adds the db_estado signal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface controle_exibicao_if;
    logic       iniciar;
    logic       cancela;
    logic [3:0] limite;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
`ifdef CONTROLE_EXIBICAO_DB_ESTADO_EN
    logic [3:0] db_estado;

    modport slave  (input  iniciar, cancela, limite, dado_mem,
                    output endereco, leds, ocupado, pronto, db_estado);
    modport master (output iniciar, cancela, limite, dado_mem,
                    input  endereco, leds, ocupado, pronto, db_estado);
`else
    modport slave  (input  iniciar, cancela, limite, dado_mem,
                    output endereco, leds, ocupado, pronto);
    modport master (output iniciar, cancela, limite, dado_mem,
                    input  endereco, leds, ocupado, pronto);
`endif
endinterface

`default_nettype wire

// File: rtl/controle_exibicao.sv
// ============================================================================
// Module      : controle_exibicao
// Description : Plays memory positions 0..limite on one-hot LEDs with lit/dark
//               timing. Macro CONTROLE_EXIBICAO_DB_ESTADO_EN exposes db_estado.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_exibicao #(
    parameter int TEMPO_ACESO   = 500,
    parameter int TEMPO_APAGADO = 250
) (
    input  wire logic             clock,
    input  wire logic             reset,
    controle_exibicao_if.slave    bus
);

    localparam int c_TMAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    // Timer only ever holds 0..c_TMAX-1.
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    localparam logic [c_TW-1:0] c_ACESO_FIM   = c_TW'(TEMPO_ACESO - 1);
    localparam logic [c_TW-1:0] c_APAGADO_FIM = c_TW'(TEMPO_APAGADO - 1);
    localparam logic [c_TW-1:0] c_UM          = c_TW'(1);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CARREGA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

    estado_t         r_estado;
    logic [c_TW-1:0] r_timer;
    logic [3:0]      r_endereco;
    logic [3:0]      r_leds;
    logic [3:0]      r_limite;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_timer    <= '0;
            r_endereco <= 4'd0;
            r_leds     <= 4'd0;
            r_limite   <= 4'd0;
        end else if (bus.cancela) begin
            r_estado   <= INICIAL;
            r_timer    <= '0;
            r_endereco <= 4'd0;
        end else begin
            case (r_estado)
                INICIAL: begin
                    r_timer    <= '0;
                    r_endereco <= 4'd0;
                    if (bus.iniciar) begin
                        r_limite <= bus.limite;
                        r_estado <= CARREGA;
                    end
                end
                CARREGA: begin
                    r_leds   <= bus.dado_mem;
                    r_timer  <= '0;
                    r_estado <= ACESO;
                end
                ACESO: begin
                    if (r_timer == c_ACESO_FIM) begin
                        r_timer  <= '0;
                        r_estado <= APAGADO;
                    end else begin
                        r_timer <= r_timer + c_UM;
                    end
                end
                APAGADO: begin
                    if (r_timer == c_APAGADO_FIM) begin
                        r_timer <= '0;
                        // Stopping on the limit keeps endereco from ever wrapping.
                        if (r_endereco == r_limite) begin
                            r_estado <= FIM;
                        end else begin
                            r_endereco <= r_endereco + 4'd1;
                            r_estado   <= CARREGA;
                        end
                    end else begin
                        r_timer <= r_timer + c_UM;
                    end
                end
                FIM: begin
                    r_endereco <= 4'd0;
                    r_estado   <= INICIAL;
                end
                default: begin
                    r_timer    <= '0;
                    r_endereco <= 4'd0;
                    r_estado   <= INICIAL;
                end
            endcase
        end
    end

    assign bus.endereco = r_endereco;
    assign bus.leds     = (r_estado == ACESO) ? r_leds : 4'd0;
    assign bus.ocupado  = (r_estado != INICIAL);
    assign bus.pronto   = (r_estado == FIM);
`ifdef CONTROLE_EXIBICAO_DB_ESTADO_EN
    assign bus.db_estado = r_estado;
`endif

endmodule

`default_nettype wire

// File: tb/tb_controle_exibicao.sv
// ============================================================================
// Module      : tb_controle_exibicao
// Description : Directed self-checking bench for controle_exibicao (lit=3, dark=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_exibicao;

    localparam int c_ACESO   = 3;
    localparam int c_APAGADO = 2;
    localparam int c_PER     = 1 + c_ACESO + c_APAGADO;

    logic       clock;
    logic       reset;
    logic [3:0] mem [16];
    int         checks;
    int         errors;

    controle_exibicao_if bus ();

    controle_exibicao #(
        .TEMPO_ACESO   (c_ACESO),
        .TEMPO_APAGADO (c_APAGADO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.dado_mem = mem[bus.endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs n cycles after iniciar was sampled, for latched limite L.
    function automatic logic [3:0] e_leds(int n, int L);
        int p;
        if (n < 1 || n > (L + 1) * c_PER) return 4'd0;
        p = (n - 1) % c_PER;
        return (p >= 1 && p <= c_ACESO) ? mem[(n - 1) / c_PER] : 4'd0;
    endfunction

    function automatic logic [3:0] e_end(int n, int L);
        if (n < 1) return 4'd0;
        if (n <= (L + 1) * c_PER) return 4'((n - 1) / c_PER);
        if (n == (L + 1) * c_PER + 1) return 4'(L);
        return 4'd0;
    endfunction

    function automatic logic e_busy(int n, int L);
        return (n >= 1 && n <= (L + 1) * c_PER + 1);
    endfunction

    function automatic logic e_pronto(int n, int L);
        return (n == (L + 1) * c_PER + 1);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        bus.iniciar = 1'b0;
        bus.cancela = 1'b0;
        bus.limite  = 4'd0;
        reset       = 1'b1;
        tick;
        tick;
        checks += 4;
        if (bus.endereco !== 4'd0) begin errors++; $display("FAIL rst_endereco got %h exp 0", bus.endereco); end
        if (bus.leds !== 4'd0)     begin errors++; $display("FAIL rst_leds got %b exp 0000", bus.leds); end
        if (bus.ocupado !== 1'b0)  begin errors++; $display("FAIL rst_ocupado got %b exp 0", bus.ocupado); end
        if (bus.pronto !== 1'b0)   begin errors++; $display("FAIL rst_pronto got %b exp 0", bus.pronto); end
`ifdef CONTROLE_EXIBICAO_DB_ESTADO_EN
        checks++;
        if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL rst_db_estado got %0d exp 0", bus.db_estado); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_sequence;
        mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b0010;
        bus.limite  = 4'd2;
        bus.iniciar = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick;
            bus.iniciar = 1'b0;
            checks += 4;
            if (bus.leds !== e_leds(n, 2))     begin errors++; $display("FAIL seq_leds n=%0d got %b exp %b", n, bus.leds, e_leds(n, 2)); end
            if (bus.endereco !== e_end(n, 2))  begin errors++; $display("FAIL seq_end n=%0d got %0d exp %0d", n, bus.endereco, e_end(n, 2)); end
            if (bus.ocupado !== e_busy(n, 2))  begin errors++; $display("FAIL seq_ocupado n=%0d got %b exp %b", n, bus.ocupado, e_busy(n, 2)); end
            if (bus.pronto !== e_pronto(n, 2)) begin errors++; $display("FAIL seq_pronto n=%0d got %b exp %b", n, bus.pronto, e_pronto(n, 2)); end
        end
    endtask

    task automatic test_limite_zero;
        mem[0] = 4'b1000;
        bus.limite  = 4'd0;
        bus.iniciar = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick;
            bus.iniciar = 1'b0;
            checks += 3;
            if (bus.leds !== e_leds(n, 0))     begin errors++; $display("FAIL lim0_leds n=%0d got %b exp %b", n, bus.leds, e_leds(n, 0)); end
            if (bus.ocupado !== e_busy(n, 0))  begin errors++; $display("FAIL lim0_ocupado n=%0d got %b exp %b", n, bus.ocupado, e_busy(n, 0)); end
            if (bus.pronto !== e_pronto(n, 0)) begin errors++; $display("FAIL lim0_pronto n=%0d got %b exp %b", n, bus.pronto, e_pronto(n, 0)); end
        end
    endtask

    task automatic test_ignore_iniciar;
        mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b0010; mem[3] = 4'b1000;
        bus.limite  = 4'd2;
        bus.iniciar = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick;
            bus.iniciar = (n == 8);
            if (n == 8) bus.limite = 4'd5;
            checks += 4;
            if (bus.leds !== e_leds(n, 2))     begin errors++; $display("FAIL ign_leds n=%0d got %b exp %b", n, bus.leds, e_leds(n, 2)); end
            if (bus.endereco !== e_end(n, 2))  begin errors++; $display("FAIL ign_end n=%0d got %0d exp %0d", n, bus.endereco, e_end(n, 2)); end
            if (bus.ocupado !== e_busy(n, 2))  begin errors++; $display("FAIL ign_ocupado n=%0d got %b exp %b", n, bus.ocupado, e_busy(n, 2)); end
            if (bus.pronto !== e_pronto(n, 2)) begin errors++; $display("FAIL ign_pronto n=%0d got %b exp %b", n, bus.pronto, e_pronto(n, 2)); end
        end
        bus.iniciar = 1'b0;
    endtask

    task automatic test_cancela;
        bus.limite  = 4'd2;
        bus.iniciar = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick;
            bus.iniciar = 1'b0;
            checks += 2;
            if (bus.leds !== e_leds(n, 2))    begin errors++; $display("FAIL can_leds n=%0d got %b exp %b", n, bus.leds, e_leds(n, 2)); end
            if (bus.endereco !== e_end(n, 2)) begin errors++; $display("FAIL can_end n=%0d got %0d exp %0d", n, bus.endereco, e_end(n, 2)); end
        end
        bus.cancela = 1'b1;
        tick;
        bus.cancela = 1'b0;
        checks += 3;
        if (bus.leds !== 4'd0)     begin errors++; $display("FAIL can_idle_leds got %b exp 0000", bus.leds); end
        if (bus.endereco !== 4'd0) begin errors++; $display("FAIL can_idle_end got %0d exp 0", bus.endereco); end
        if (bus.ocupado !== 1'b0)  begin errors++; $display("FAIL can_idle_ocupado got %b exp 0", bus.ocupado); end
        for (int n = 0; n < 12; n++) begin
            checks++;
            if (bus.pronto !== 1'b0) begin errors++; $display("FAIL can_pronto n=%0d got %b exp 0", n, bus.pronto); end
            tick;
        end
    endtask

    task automatic test_reset_mid_and_full;
        bus.limite  = 4'd2;
        bus.iniciar = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick;
            bus.iniciar = 1'b0;
        end
        reset = 1'b1; bus.iniciar = 1'b1; bus.cancela = 1'b1;
        tick;
        checks += 4;
        if (bus.endereco !== 4'd0) begin errors++; $display("FAIL rmid_end got %0d exp 0", bus.endereco); end
        if (bus.leds !== 4'd0)     begin errors++; $display("FAIL rmid_leds got %b exp 0000", bus.leds); end
        if (bus.ocupado !== 1'b0)  begin errors++; $display("FAIL rmid_ocupado got %b exp 0", bus.ocupado); end
        if (bus.pronto !== 1'b0)   begin errors++; $display("FAIL rmid_pronto got %b exp 0", bus.pronto); end
        for (int i = 0; i < 16; i++) mem[i] = (i % 5 == 0) ? 4'd0 : 4'(1 << (i % 4));
        reset = 1'b0; bus.cancela = 1'b0; bus.limite = 4'd15;
        for (int n = 1; n <= 98; n++) begin
            tick;
            bus.iniciar = 1'b0;
            checks += 4;
            if (bus.leds !== e_leds(n, 15))     begin errors++; $display("FAIL full_leds n=%0d got %b exp %b", n, bus.leds, e_leds(n, 15)); end
            if (bus.endereco !== e_end(n, 15))  begin errors++; $display("FAIL full_end n=%0d got %0d exp %0d", n, bus.endereco, e_end(n, 15)); end
            if (bus.ocupado !== e_busy(n, 15))  begin errors++; $display("FAIL full_ocupado n=%0d got %b exp %b", n, bus.ocupado, e_busy(n, 15)); end
            if (bus.pronto !== e_pronto(n, 15)) begin errors++; $display("FAIL full_pronto n=%0d got %b exp %b", n, bus.pronto, e_pronto(n, 15)); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        test_reset;
        test_sequence;
        test_limite_zero;
        test_ignore_iniciar;
        test_cancela;
        test_reset_mid_and_full;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controle_exibicao.md
CONTROLE_EXIBICAO -- requirements
Module: controle_exibicao

Interface
REQ-001 SHALL have parameter TEMPO_ACESO, default 500, clock cycles each sequence LED stays lit (>=1).
REQ-002 SHALL have parameter TEMPO_APAGADO, default 250, clock cycles of dark gap after each LED (>=1).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port iniciar  input  1  start playback request, sampled only in state INICIAL.
REQ-006 SHALL have port cancela  input  1  abort playback, return to INICIAL without pronto.
REQ-007 SHALL have port limite  input  4  address of last memory position to show (round index).
REQ-008 SHALL have port dado_mem  input  4  memory read data, valid one cycle after endereco changes.
REQ-009 SHALL have port endereco  output  4  memory address being played.
REQ-010 SHALL have port leds  output  4  one-hot LED drive; 0 when dark.
REQ-011 SHALL have port ocupado  output  1  high in every state except INICIAL.
REQ-012 SHALL have port pronto  output  1  single-cycle pulse when playback completes.
REQ-013 SHALL have port db_estado  output  4  state code, present only per REQ-031.

Function
REQ-014 SHALL implement states INICIAL=0, CARREGA=1, ACESO=2, APAGADO=3, FIM=4; other codes SHALL go to INICIAL next cycle.
REQ-015 INICIAL: endereco=0, leds=0; on iniciar=1 SHALL latch limite into internal register and go to CARREGA.
REQ-016 CARREGA (exactly 1 cycle): SHALL register dado_mem into LED register, clear timer, go to ACESO.
REQ-017 ACESO: leds SHALL equal LED register; after TEMPO_ACESO cycles SHALL go to APAGADO with timer cleared.
REQ-018 APAGADO: leds=0; after TEMPO_APAGADO cycles SHALL go to FIM if endereco equals latched limite, else increment endereco and go to CARREGA.
REQ-019 FIM: pronto=1 for exactly that cycle, then INICIAL.
REQ-020 Latency: if iniciar sampled in cycle k, pronto SHALL be high in cycle k+1+(L+1)*(1+TEMPO_ACESO+TEMPO_APAGADO), L = latched limite.
REQ-021 iniciar while ocupado=1 SHALL be ignored; limite changes after latch SHALL not affect playback.
REQ-022 cancela=1 in any state SHALL force INICIAL next cycle (endereco=0, leds=0, no pronto); cancela has priority over iniciar.
REQ-023 limite=15 SHALL play addresses 0..15; endereco SHALL never wrap past 15.
REQ-024 dado_mem=0 SHALL yield leds=0 during ACESO with timing unchanged.
REQ-025 Timer width SHALL cover max(TEMPO_ACESO, TEMPO_APAGADO) without overflow.
REQ-026 All outputs SHALL be registered or decoded from registered state only (no combinational path from inputs).

Reset
REQ-027 reset=1 SHALL force, on next clock edge, state INICIAL, endereco=0, leds=0, ocupado=0, pronto=0, timer=0, latched limite=0.
REQ-028 reset SHALL have priority over cancela and iniciar, including mid-playback.
REQ-029 After reset release, iniciar SHALL be accepted on the first cycle.

Configuration
REQ-030 Macro CONTROLE_EXIBICAO_DB_ESTADO_EN SHALL control the debug state output.
REQ-031 With macro defined: port db_estado SHALL exist and carry state code per REQ-014; without: port db_estado SHALL be absent and all other behaviour identical.

Verification (TEMPO_ACESO=3, TEMPO_APAGADO=2)
REQ-032 Reset, iniciar at k, limite=2, memory {1,4,2} -> leds 0001,0100,0010 each 3 cycles with 2-cycle gaps; pronto only at cycle k+19; endereco 0,1,2.
REQ-033 limite=0, dado_mem=8 -> one lit period of 1000, pronto at k+7, ocupado low at k+8.
REQ-034 iniciar pulsed and limite changed to 5 during ACESO of address 1 (limite=2 latched) -> ignored, pronto at k+19, endereco max 2.
REQ-035 cancela=1 during APAGADO of address 1 -> next cycle INICIAL, leds=0, endereco=0, pronto never asserted.
REQ-036 reset=1 concurrent with iniciar=1 and cancela=1 mid-playback -> all outputs at reset values next cycle; limite=15 run then shows addresses 0..15, pronto at k+97.
